osd_candidate_scheduler: RTL and testbench

OSD_CANDIDATE_SCHEDULER -- requirements
Module: osd_candidate_scheduler

---
 rtl/osd_candidate_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_osd_candidate_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_candidate_scheduler.sv
// Order-1 OSD candidate scheduler: walks flip patterns over the MRB, scores each re-encoded codeword, keeps the lowest metric (build option OSD_ORDER2_EN adds double flips).
// Latency: done pulses 2 + sum(2 + ACC bits scored) cycles after start is sampled; ACC exits early once the running best is matched.
// Backpressure: none; start is only sampled in IDLE, and inputs are captured once in LOAD.
module osd_candidate_scheduler #(
  parameter int K = 4,
  parameter int N = 8,
  parameter int W = 6,
  localparam int MW = W + $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N-1:0]      hard_in,
  input  logic [N*W-1:0]    rel_flat,
  output logic [K-1:0]      enc_cand,
  input  logic [N-1:0]      enc_cw,
  output logic              busy,
  output logic              done,
  output logic [K-1:0]      best_candidate,
  output logic [N-1:0]      best_codeword,
  output logic [MW-1:0]     best_metric
);

`ifdef OSD_ORDER2_EN
  localparam int NC = 1 + K + (K * (K - 1)) / 2;
  localparam int JW = (K > 2) ? $clog2(K) : 1;
`else
  localparam int NC = 1 + K;
`endif
  localparam int IW = $clog2(NC);
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ENC  = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_UPD  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]     state;
  logic [N-1:0]   hard_q;
  logic [N*W-1:0] rel_q;
  logic [N-1:0]   cw_q;
  logic [IW-1:0]  idx;
  logic [BW-1:0]  bi;
  logic [MW-1:0]  acc;
  logic [MW-1:0]  run_metric;
  logic [K-1:0]   run_cand;
  logic [N-1:0]   run_cw;
  logic           accepted;
`ifdef OSD_ORDER2_EN
  logic [JW-1:0]  pj;
  logic [JW-1:0]  pm;
`endif

  logic [K-1:0]   mask;
  logic [K-1:0]   cand;
  logic [W-1:0]   rel_bit;
  logic [MW-1:0]  add;
  logic [MW-1:0]  acc_nxt;
  logic           last_cand;

  // Candidate 0 is the hard MRB; 1..K flip one bit; the pair registers cover the rest.
  always_comb begin
    mask = '0;
    if (idx == '0) begin
      mask = '0;
    end else if (idx <= IW'(K)) begin
      mask = K'(1) << (idx - IW'(1));
    end else begin
`ifdef OSD_ORDER2_EN
      mask = (K'(1) << pj) | (K'(1) << pm);
`else
      mask = '0;
`endif
    end
  end

  assign cand      = hard_q[K-1:0] ^ mask;
  assign last_cand = (idx == IW'(NC - 1));
  assign rel_bit   = rel_q[bi*W +: W];
  assign add       = (cw_q[bi] ^ hard_q[bi]) ? {{(MW-W){1'b0}}, rel_bit} : '0;
  assign acc_nxt   = acc + add;

  assign busy     = (state != S_IDLE);
  assign enc_cand = (state == S_ENC) ? cand : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      hard_q         <= '0;
      rel_q          <= '0;
      cw_q           <= '0;
      idx            <= '0;
      bi             <= '0;
      acc            <= '0;
      run_metric     <= '0;
      run_cand       <= '0;
      run_cw         <= '0;
      accepted       <= 1'b0;
      done           <= 1'b0;
      best_candidate <= '0;
      best_codeword  <= '0;
      best_metric    <= '0;
`ifdef OSD_ORDER2_EN
      pj             <= '0;
      pm             <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_LOAD;
        end
        S_LOAD: begin
          hard_q     <= hard_in;
          rel_q      <= rel_flat;
          idx        <= '0;
          acc        <= '0;
          run_metric <= '1;
          state      <= S_ENC;
        end
        S_ENC: begin
          cw_q  <= enc_cw;
          acc   <= '0;
          bi    <= '0;
          state <= S_ACC;
        end
        S_ACC: begin
          acc <= acc_nxt;
          // A tie with the running best is a loss, so earlier candidates win ties.
          if (acc_nxt >= run_metric) begin
            accepted <= 1'b0;
            state    <= S_UPD;
          end else if (bi == BW'(N - 1)) begin
            accepted <= 1'b1;
            state    <= S_UPD;
          end else begin
            bi <= bi + BW'(1);
          end
        end
        S_UPD: begin
          if (accepted) begin
            run_cand   <= cand;
            run_cw     <= cw_q;
            run_metric <= acc;
          end
          if (last_cand) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + IW'(1);
            state <= S_ENC;
`ifdef OSD_ORDER2_EN
            if (idx == IW'(K)) begin
              pj <= '0;
              pm <= JW'(1);
            end else if (idx > IW'(K)) begin
              if (pm == JW'(K - 1)) begin
                pj <= pj + JW'(1);
                pm <= pj + JW'(2);
              end else begin
                pm <= pm + JW'(1);
              end
            end
`endif
          end
        end
        S_DONE: begin
          best_candidate <= run_cand;
          best_codeword  <= run_cw;
          best_metric    <= run_metric;
          done           <= 1'b1;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_candidate_scheduler.sv
// Bench for osd_candidate_scheduler with an [8,4] systematic re-encoder and a candidate-list reference model.
module tb_osd_candidate_scheduler;
  localparam int K  = 4;
  localparam int N  = 8;
  localparam int W  = 6;
  localparam int MW = W + $clog2(N + 1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   hard_in;
  logic [N*W-1:0] rel_flat;
  logic [K-1:0]   enc_cand;
  logic [N-1:0]   enc_cw;
  logic           busy;
  logic           done;
  logic [K-1:0]   best_candidate;
  logic [N-1:0]   best_codeword;
  logic [MW-1:0]  best_metric;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] prow(input int j);
    case (j)
      0:       return 4'b0111;
      1:       return 4'b1011;
      2:       return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  function automatic logic [N-1:0] encode(input logic [K-1:0] m);
    logic [3:0] p;
    p = '0;
    for (int j = 0; j < K; j++) if (m[j]) p = p ^ prow(j);
    return {p, m};
  endfunction

  function automatic logic [N*W-1:0] rel_all(input int v);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [N*W-1:0] rel_rand();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  assign enc_cw = encode(enc_cand);

  osd_candidate_scheduler #(.K(K), .N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hard_in(hard_in), .rel_flat(rel_flat),
    .enc_cand(enc_cand), .enc_cw(enc_cw), .busy(busy), .done(done),
    .best_candidate(best_candidate), .best_codeword(best_codeword), .best_metric(best_metric)
  );

  // Reference: enumerate the candidate list, score each, reject on reaching the running best.
  task automatic model(input logic [N-1:0] h, input logic [N*W-1:0] r,
                       output logic [K-1:0] bc, output logic [N-1:0] bcw, output int bm, output int lat);
    logic [K-1:0] cl[$];
    logic [K-1:0] base;
    logic [N-1:0] cw;
    int best, acc, bits;
    bit rej;
    base = h[K-1:0];
    cl.push_back(base);
    for (int j = 0; j < K; j++) cl.push_back(base ^ (K'(1) << j));
`ifdef OSD_ORDER2_EN
    for (int j = 0; j < K; j++)
      for (int m = j + 1; m < K; m++) cl.push_back(base ^ (K'(1) << j) ^ (K'(1) << m));
`endif
    best = (1 << MW) - 1;
    lat  = 2;
    bc   = '0;
    bcw  = '0;
    foreach (cl[c]) begin
      cw = encode(cl[c]);
      acc = 0; bits = 0; rej = 0;
      for (int i = 0; i < N; i++) begin
        if (cw[i] != h[i]) acc += int'(r[i*W +: W]);
        bits++;
        if (acc >= best) begin rej = 1; break; end
      end
      lat += 2 + bits;
      if (!rej) begin best = acc; bc = cl[c]; bcw = cw; end
    end
    bm = best;
  endtask

  task automatic run_dut(input logic [N-1:0] h, input logic [N*W-1:0] r, input int restart_at,
                         output logic [K-1:0] bc, output logic [N-1:0] bcw, output int bm,
                         output int lat, output int ndone);
    int cyc;
    @(negedge clk);
    hard_in = h; rel_flat = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 0; ndone = 0; lat = -1;
    while (cyc < 2000 && lat < 0) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin hard_in = N'($urandom); rel_flat = rel_rand(); end
      start = (cyc == restart_at);
      if (done) begin lat = cyc; ndone++; end
    end
    start = 1'b0;
    bc = best_candidate; bcw = best_codeword; bm = int'(best_metric);
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; hard_in = '0; rel_flat = '0;
    #12;
    checks++;
    if ({busy, done, enc_cand, best_candidate, best_codeword, best_metric} !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b cand=%h cw=%h metric=%0d expected all zero",
               busy, done, best_candidate, best_codeword, best_metric);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || enc_cand !== '0) begin
      failures++;
      $display("FAIL reset_idle busy=%b enc_cand=%h expected 0/0", busy, enc_cand);
    end
  endtask

  task automatic test_valid_codeword();
    logic [K-1:0] bc; logic [N-1:0] bcw; int bm, lat, nd;
    logic [N-1:0] h;
    h = encode(4'b1011);
    run_dut(h, rel_all(10), -1, bc, bcw, bm, lat, nd);
    checks++;
    if (bc !== 4'b1011) begin failures++; $display("FAIL valid_cand got=%h exp=%h", bc, 4'b1011); end
    checks++;
    if (bm != 0) begin failures++; $display("FAIL valid_metric got=%0d exp=0", bm); end
    checks++;
    if (bcw !== h) begin failures++; $display("FAIL valid_cw got=%h exp=%h", bcw, h); end
    checks++;
    if (lat != 24) begin failures++; $display("FAIL valid_latency got=%0d exp=24", lat); end
    checks++;
    if (nd != 1) begin failures++; $display("FAIL valid_done_count got=%0d exp=1", nd); end
  endtask

  task automatic test_single_flip();
    logic [K-1:0] bc, mc; logic [N-1:0] bcw, mcw; int bm, lat, nd, mm, ml;
    logic [N-1:0] h; logic [N*W-1:0] r;
    h = encode(4'b0101) ^ N'(4);
    r = rel_all(20); r[2*W +: W] = W'(1);
    model(h, r, mc, mcw, mm, ml);
    run_dut(h, r, -1, bc, bcw, bm, lat, nd);
    checks++;
    if (bc !== 4'b0101) begin failures++; $display("FAIL flip_cand got=%h exp=%h", bc, 4'b0101); end
    checks++;
    if (bm != 1) begin failures++; $display("FAIL flip_metric got=%0d exp=1", bm); end
    checks++;
    if (lat != ml) begin failures++; $display("FAIL flip_latency got=%0d exp=%0d", lat, ml); end
  endtask

  task automatic test_tie();
    logic [K-1:0] bc; logic [N-1:0] bcw; int bm, lat, nd;
    logic [N-1:0] h; logic [N*W-1:0] r;
    h = encode(4'b0110) ^ N'(8'h10);
    r = rel_all(20);
    r[4*W +: W] = W'(5); r[0*W +: W] = W'(1); r[5*W +: W] = W'(2); r[6*W +: W] = W'(2);
    run_dut(h, r, -1, bc, bcw, bm, lat, nd);
    checks++;
    if (bc !== 4'b0110) begin failures++; $display("FAIL tie_cand got=%h exp=%h", bc, 4'b0110); end
    checks++;
    if (bm != 5) begin failures++; $display("FAIL tie_metric got=%0d exp=5", bm); end
  endtask

  task automatic test_start_ignored();
    logic [K-1:0] bc; logic [N-1:0] bcw; int bm, lat, nd;
    logic [N-1:0] h;
    h = encode(4'b1100);
    run_dut(h, rel_all(10), 5, bc, bcw, bm, lat, nd);
    checks++;
    if (nd != 1) begin failures++; $display("FAIL restart_done_count got=%0d exp=1", nd); end
    checks++;
    if (lat != 24) begin failures++; $display("FAIL restart_latency got=%0d exp=24", lat); end
    checks++;
    if (bc !== 4'b1100 || bm != 0) begin
      failures++; $display("FAIL restart_result cand=%h metric=%0d exp cand=c metric=0", bc, bm);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [K-1:0] bc, mc; logic [N-1:0] bcw, mcw; int bm, lat, nd, mm, ml, seen;
    logic [N-1:0] h;
    h = encode(4'b0011);
    @(negedge clk);
    hard_in = h; rel_flat = rel_all(10); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; seen = 0;
    repeat (10) begin @(posedge clk); #1; if (done) seen++; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++;
    if ({best_candidate, best_codeword, best_metric, enc_cand} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs cand=%h cw=%h metric=%0d enc=%h exp all zero",
               best_candidate, best_codeword, best_metric, enc_cand);
    end
    repeat (30) begin @(posedge clk); #1; if (done) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL midreset_no_done got=%0d pulses exp=0", seen); end
    @(negedge clk); rst_n = 1'b1;
    model(h, rel_all(10), mc, mcw, mm, ml);
    run_dut(h, rel_all(10), -1, bc, bcw, bm, lat, nd);
    checks++;
    if (bc !== mc || bm != mm || lat != ml) begin
      failures++;
      $display("FAIL midreset_rerun cand=%h metric=%0d lat=%0d exp cand=%h metric=%0d lat=%0d",
               bc, bm, lat, mc, mm, ml);
    end
  endtask

  task automatic test_random();
    logic [K-1:0] bc, mc; logic [N-1:0] bcw, mcw; int bm, lat, nd, mm, ml;
    logic [N-1:0] h; logic [N*W-1:0] r;
    for (int t = 0; t < 25; t++) begin
      h = N'($urandom);
      r = rel_rand();
      model(h, r, mc, mcw, mm, ml);
      run_dut(h, r, -1, bc, bcw, bm, lat, nd);
      checks++;
      if (bc !== mc || bcw !== mcw || bm != mm) begin
        failures++;
        $display("FAIL random_result t=%0d cand=%h cw=%h metric=%0d exp cand=%h cw=%h metric=%0d",
                 t, bc, bcw, bm, mc, mcw, mm);
      end
      checks++;
      if (lat != ml || nd != 1) begin
        failures++;
        $display("FAIL random_timing t=%0d lat=%0d done=%0d exp lat=%0d done=1", t, lat, nd, ml);
      end
      hard_in = N'($urandom); rel_flat = rel_rand();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (best_candidate !== mc || best_codeword !== mcw || int'(best_metric) != mm ||
          enc_cand !== '0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL random_hold t=%0d cand=%h cw=%h metric=%0d enc=%h busy=%b exp cand=%h cw=%h metric=%0d enc=0 busy=0",
                 t, best_candidate, best_codeword, best_metric, enc_cand, busy, mc, mcw, mm);
      end
    end
  endtask

`ifdef OSD_ORDER2_EN
  task automatic test_order2();
    logic [K-1:0] bc, mc; logic [N-1:0] bcw, mcw; int bm, lat, nd, mm, ml;
    logic [N-1:0] h; logic [N*W-1:0] r;
    h = encode(4'b0110) ^ N'(8'h09);
    r = rel_all(30); r[0*W +: W] = W'(1); r[3*W +: W] = W'(1);
    model(h, r, mc, mcw, mm, ml);
    run_dut(h, r, -1, bc, bcw, bm, lat, nd);
    checks++;
    if (bc !== 4'b0110 || bm != 2) begin
      failures++; $display("FAIL order2_result cand=%h metric=%0d exp cand=6 metric=2", bc, bm);
    end
    checks++;
    if (lat != ml) begin failures++; $display("FAIL order2_latency got=%0d exp=%0d", lat, ml); end
  endtask
`endif

  initial begin
    test_reset();
    test_valid_codeword();
    test_single_flip();
    test_tie();
    test_start_ignored();
    test_reset_mid_run();
    test_random();
`ifdef OSD_ORDER2_EN
    test_order2();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
